// File: rtl/cmos_pkg.sv
// rtl/cmos_pkg.sv - shared types and constants for the camera pixel packer
// Contents:
//   state_t        capture state machine encoding
//   BYTES_PER_WORD camera bytes per 32-bit output word
//   LINE_CNT_W     width of the completed-line counter
//   byte_cnt_w()   width of a per-line byte counter covering 0..2*h_active
package cmos_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKIP,
        ST_SYNC,
        ST_ACTIVE,
        ST_VBLANK
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LINE_CNT_W     = 12;

    function automatic int byte_cnt_w(input int h_active);
        return $clog2(2 * h_active + 1);
    endfunction

endpackage

// File: rtl/cmos_pixel_packer_if.sv
// rtl/cmos_pixel_packer_if.sv - camera byte stream in, DDR write word out
// Signals:
//   cmos_vsync  frame sync, high during vertical blanking
//   cmos_href   line valid, high during active bytes
//   cmos_d      camera byte
//   ddr_wren    one-cycle write strobe for ddr_data
//   ddr_data    [31:16] earlier pixel, [15:0] later pixel
// Modports:
//   master  camera/DDR environment side
//   slave   packer side
interface cmos_pixel_packer_if;

    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_d;
    logic        ddr_wren;
    logic [31:0] ddr_data;

    modport master (
        output cmos_vsync,
        output cmos_href,
        output cmos_d,
        input  ddr_wren,
        input  ddr_data
    );

    modport slave (
        input  cmos_vsync,
        input  cmos_href,
        input  cmos_d,
        output ddr_wren,
        output ddr_data
    );

endinterface

// File: rtl/cmos_input_sync.sv
// rtl/cmos_input_sync.sv - stage-1 camera input registers and edge pulses
// Ports:
//   clk, rst_n             pixel clock, synchronous active-low reset
//   cmos_vsync/href/d      raw camera inputs
//   href_s, data_s         stage-1 registered href and byte
//   vsync_rise/vsync_fall  vsync edges seen between stage 1 and its delayed copy
//   href_fall              href falling edge, same alignment
module cmos_input_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmos_vsync,
    input  logic       cmos_href,
    input  logic [7:0] cmos_d,
    output logic       href_s,
    output logic [7:0] data_s,
    output logic       vsync_rise,
    output logic       vsync_fall,
    output logic       href_fall
);

    logic vsync_s;
    logic vsync_d;
    logic href_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_s <= 1'b0;
            href_s  <= 1'b0;
            data_s  <= 8'h00;
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_s <= cmos_vsync;
            href_s  <= cmos_href;
            data_s  <= cmos_d;
            vsync_d <= vsync_s;
            href_d  <= href_s;
        end
    end

    assign vsync_rise = vsync_s & ~vsync_d;
    assign vsync_fall = ~vsync_s & vsync_d;
    assign href_fall  = ~href_s & href_d;

endmodule

// File: rtl/cmos_pixel_packer.sv
// rtl/cmos_pixel_packer.sv - packs OV5640 RGB565 bytes into 32-bit DDR words
// Ports:
//   clk, rst_n    camera pixel clock, synchronous active-low reset
//   init_done     DDR and camera configuration complete (level)
//   bus           camera stream in, ddr_wren/ddr_data out
//   frame_start   pulse when a captured frame begins
//   frame_done    pulse when a captured frame ends
//   frame_err     geometry status of the last completed frame (held)
//   line_cnt      lines completed in the current frame
module cmos_pixel_packer
    import cmos_pkg::*;
#(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int SKIP_FRAMES = 10,
    parameter int BYTE_SWAP   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_done,
    cmos_pixel_packer_if.slave    bus,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [LINE_CNT_W-1:0] line_cnt
);

    localparam int BC_W   = byte_cnt_w(H_ACTIVE);
    localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);

    localparam logic [BC_W-1:0]       LINE_BYTES = BC_W'(2 * H_ACTIVE);
    localparam logic [LINE_CNT_W-1:0] LINES      = LINE_CNT_W'(V_ACTIVE);
    localparam logic [SKIP_W-1:0]     SKIP_LAST  = SKIP_W'(SKIP_FRAMES);
    localparam logic [1:0]            LAST_PHASE = 2'(BYTES_PER_WORD - 1);
    // Swapping the two bytes of each pixel is the same as flipping bit 0
    // of the lane index.
    localparam logic [1:0]            LANE_XOR   = (BYTE_SWAP != 0) ? 2'b01 : 2'b00;

    logic       href_s;
    logic [7:0] data_s;
    logic       vsync_rise;
    logic       vsync_fall;
    logic       href_fall;

    cmos_input_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmos_vsync (bus.cmos_vsync),
        .cmos_href  (bus.cmos_href),
        .cmos_d     (bus.cmos_d),
        .href_s     (href_s),
        .data_s     (data_s),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .href_fall  (href_fall)
    );

    state_t                state;
    state_t                state_n;
    logic [SKIP_W-1:0]     skip_cnt;
    logic [1:0]            phase;
    logic [BC_W-1:0]       byte_cnt;
    logic [31:0]           acc;
    logic                  word_rdy;
    logic                  err_flag;

    logic                  take_byte;
    logic                  keep_byte;
    logic                  line_end;
    logic                  trunc;
    logic                  line_full;
    logic                  lines_full;
    logic                  err_set;
    logic                  start_n;
    logic                  done_n;
    logic [1:0]            slot;
    logic [31:0]           acc_n;
    logic [LINE_CNT_W-1:0] line_cnt_n;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (init_done) state_n = (SKIP_FRAMES > 0) ? ST_SKIP : ST_SYNC;
            ST_SKIP:   if (vsync_rise && (skip_cnt + 1'b1 == SKIP_LAST)) state_n = ST_SYNC;
            ST_SYNC:   if (vsync_fall) state_n = ST_ACTIVE;
            ST_ACTIVE: if (vsync_rise) state_n = ST_VBLANK;
            ST_VBLANK: if (vsync_fall) state_n = ST_ACTIVE;
            default:   state_n = ST_IDLE;
        endcase
        if (!init_done) state_n = ST_IDLE;
    end

    always_comb begin
        lines_full = (line_cnt == LINES);
        line_full  = (byte_cnt == LINE_BYTES);
        // A vsync rise with href still high truncates the line: that byte is
        // not packed and the partial word is abandoned.
        take_byte  = (state == ST_ACTIVE) && href_s && !vsync_rise;
        keep_byte  = take_byte && !lines_full && !line_full;
        line_end   = (state == ST_ACTIVE) && href_fall;
        trunc      = (state == ST_ACTIVE) && href_s && vsync_rise;
        err_set    = (take_byte && (lines_full || line_full))
                   || (line_end && !line_full)
                   || trunc;
        line_cnt_n = (line_end && !lines_full) ? line_cnt + 1'b1 : line_cnt;
        start_n    = (state_n == ST_ACTIVE) && (state != ST_ACTIVE);
        done_n     = (state == ST_ACTIVE) && (state_n == ST_VBLANK);
        slot       = ~(phase ^ LANE_XOR);
        acc_n      = acc;
        acc_n[{slot, 3'b000} +: 8] = data_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            skip_cnt     <= '0;
            phase        <= 2'd0;
            byte_cnt     <= '0;
            acc          <= 32'h0;
            word_rdy     <= 1'b0;
            err_flag     <= 1'b0;
            line_cnt     <= '0;
            bus.ddr_wren <= 1'b0;
            bus.ddr_data <= 32'h0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_n;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            word_rdy     <= 1'b0;
            // Completed words leave one cycle after assembly.
            bus.ddr_wren <= word_rdy;
            if (word_rdy) bus.ddr_data <= acc;

            if (!init_done) begin
                bus.ddr_wren <= 1'b0;
                skip_cnt     <= '0;
                phase        <= 2'd0;
                byte_cnt     <= '0;
                err_flag     <= 1'b0;
                line_cnt     <= '0;
            end else begin
                if (state == ST_SKIP && vsync_rise) skip_cnt <= skip_cnt + 1'b1;

                if (start_n) begin
                    frame_start <= 1'b1;
                    err_flag    <= 1'b0;
                    line_cnt    <= '0;
                    phase       <= 2'd0;
                    byte_cnt    <= '0;
                end

                if (keep_byte) begin
                    acc      <= acc_n;
                    phase    <= phase + 1'b1;
                    byte_cnt <= byte_cnt + 1'b1;
                    word_rdy <= (phase == LAST_PHASE);
                end

                if (line_end || trunc) begin
                    phase    <= 2'd0;
                    byte_cnt <= '0;
                    line_cnt <= line_cnt_n;
                end

                if (err_set) err_flag <= 1'b1;

                if (done_n) begin
                    frame_done <= 1'b1;
                    frame_err  <= err_flag || err_set || (line_cnt_n != LINES);
                end
            end
        end
    end

endmodule

// File: doc/cmos_pixel_packer.md
Name: cmos_pixel_packer

Overview:
- Sits between the camera source selector and the DDR dual-FIFO write port, in the camera pixel-clock domain.
- Turns the 8-bit OV5640 RGB565 byte stream (vsync/href framed) into 32-bit two-pixel words with a write strobe.
- Holds off until DDR and camera init are done and skips the first unstable frames.
- Aligns capture to frame boundaries and polices line and frame geometry.

Parameters:
- H_ACTIVE, 1024, pixels per line (even).
- V_ACTIVE, 768, lines per frame.
- SKIP_FRAMES, 10, complete frames discarded after init_done rises (0 = none).
- BYTE_SWAP, 0, 0: first byte of a pixel is the high byte; 1: first byte is the low byte.

Ports:
- clk  in  1  camera pixel clock (cmos_pclk)
- rst_n  in  1  synchronous active-low reset
- init_done  in  1  DDR init done AND camera register config done, level
- cmos_vsync  in  1  frame sync; high during vertical blanking
- cmos_href  in  1  line valid, high during active bytes
- cmos_d  in  8  camera byte
- ddr_wren  out  1  one-cycle write strobe for ddr_data
- ddr_data  out  32  [31:16] = earlier pixel, [15:0] = later pixel
- frame_start  out  1  one-cycle pulse when a captured frame begins
- frame_done  out  1  one-cycle pulse when a captured frame ends
- frame_err  out  1  geometry status of the last completed frame, held
- line_cnt  out  12  lines completed in the current frame

Behaviour:
- Input stage: cmos_vsync, cmos_href and cmos_d are registered once (stage 1). All edge detection uses stage 1 and its one-cycle-delayed copy.
- Reset values: all outputs 0, state IDLE, counters 0, byte phase 0.
- State machine:
  - IDLE: if init_done=1, go to SKIP when SKIP_FRAMES>0, otherwise go to SYNC.
  - SKIP: count vsync rising edges. When the count reaches SKIP_FRAMES, go to SYNC.
  - SYNC: on a vsync falling edge, go to ACTIVE and pulse frame_start. No writes occur in SYNC.
  - ACTIVE: on a vsync rising edge, go to VBLANK and pulse frame_done.
  - VBLANK: on a vsync falling edge, go to ACTIVE and pulse frame_start.
- init_done low in any state: next state is IDLE. The partial word, byte phase, counters and skip count are cleared, and ddr_wren is forced 0 from the same edge onward. frame_err keeps its value.
- Packing (ACTIVE only, stage-1 href=1):
  - A 2-bit byte phase advances 0→1→2→3→0.
  - Bytes shift into a 32-bit accumulator. With BYTE_SWAP=1, the two bytes of each pixel are swapped.
  - At phase 3, ddr_data is loaded and ddr_wren=1 for exactly one cycle.
  - Latency: the 4th byte present on cmos_d at edge N produces ddr_wren high after edge N+2.
  - Maximum rate: one word per 4 clocks.
  - ddr_data holds its value between strobes.
- Per-line byte counter (range 0..2*H_ACTIVE):
  - Bytes beyond 2*H_ACTIVE are dropped (no strobe) and set the frame's error flag.
  - On an href falling edge:
    - byte count != 2*H_ACTIVE sets the error flag;
    - a nonzero phase discards the partial word (no strobe);
    - phase and byte count reset;
    - line_cnt increments, saturating at V_ACTIVE.
  - Lines beyond V_ACTIVE are dropped entirely and set the error flag.
- Frame end: at frame_done, frame_err is loaded with (error flag OR line_cnt != V_ACTIVE). The error flag and line_cnt clear on the next frame_start.
- Simultaneous events:
  - href still high when vsync rises: the line is treated as truncated (error, partial word discarded); frame_done still fires.
  - frame_done and frame_start can never coincide (separate edges).
- No backpressure: the downstream FIFO must accept every strobe.

Decomposition:
- Package cmos_pkg:
  - state enum (IDLE, SKIP, SYNC, ACTIVE, VBLANK);
  - BYTES_PER_WORD=4;
  - width constants for line_cnt (12) and byte count (derived as clog2(2*H_ACTIVE+1)).
- One sub-module cmos_input_sync: stage-1 registers plus rise/fall pulses for vsync and href.

Test Plan:
- Geometry H_ACTIVE=4, V_ACTIVE=2, SKIP_FRAMES=0; init_done=1; one frame with bytes 0x01..0x10 → 4 strobes with ddr_data 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10. frame_start before the first strobe, frame_done after the last, frame_err=0, line_cnt=2.
- Same frame with BYTE_SWAP=1 → first word 0x02010403.
- SKIP_FRAMES=2 → frames 1–2 produce no strobes and no pulses; frame 3 is captured. Check the exact strobe count is 4.
- Line of 7 bytes (one short) → 1 strobe for that line, partial word dropped, frame_err=1 at frame_done. The next clean frame returns frame_err=0.
- Line of 10 bytes, plus a 3rd line → 2 strobes per line; the 3rd line gives no strobes; frame_err=1; line_cnt saturates at 2.
- init_done dropped mid-line after 2 bytes → ddr_wren=0 thereafter and state returns to IDLE. After re-assertion, capture restarts only at the next vsync falling edge.
